// File: rtl/fp_mul_issue_if.sv
// Bundles the request, multiplier and response signals of the FP multiplier issue stage.
// slave is the issue stage's view; master is the surrounding system (requester, multiplier, consumer).
interface fp_mul_issue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_op1;
    logic [31:0]      req_op2;
    logic [TAG_W-1:0] req_tag;

    logic             mul_start;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [31:0]      mul_result;
    logic             mul_done;
    logic             mul_busy;
    logic             mul_serv;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    logic             timeout_err;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  req_valid, req_op1, req_op2, req_tag,
        input  mul_result, mul_done, mul_busy,
        input  rsp_ready,
        output req_ready, mul_start, op1, op2, mul_serv,
        output rsp_valid, rsp_result, rsp_tag, timeout_err, fifo_count
    );

    modport master (
        output req_valid, req_op1, req_op2, req_tag,
        output mul_result, mul_done, mul_busy,
        output rsp_ready,
        input  req_ready, mul_start, op1, op2, mul_serv,
        input  rsp_valid, rsp_result, rsp_tag, timeout_err, fifo_count
    );
endinterface

// File: rtl/fp_mul_issue.sv
// Issue stage for the FP multiplier: request FIFO, one-in-flight sequencer with timeout,
// and a single-entry result slot with valid/ready handshake.
module fp_mul_issue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          n_rst,
    fp_mul_issue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t           state_reg;
    logic [31:0]      mem_op1 [DEPTH];
    logic [31:0]      mem_op2 [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       wait_cnt_reg;
    logic [31:0]      op1_reg;
    logic [31:0]      op2_reg;
    logic [TAG_W-1:0] tag_q_reg;
    logic             mul_start_reg;
    logic             mul_serv_reg;
    logic             rsp_valid_reg;
    logic [31:0]      rsp_result_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
    logic             timeout_err_reg;

    logic full;
    logic empty;
    logic push;
    logic issue;

    // No pass-through: a full FIFO refuses a push even when it pops that cycle.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = bus.req_valid && !full;
    // A done still asserted in IDLE is stale and must not start or be captured again.
    assign issue = (state_reg == IDLE) && !empty && !rsp_valid_reg &&
                   !bus.mul_busy && !bus.mul_done;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op1[wr_ptr_reg] <= bus.req_op1;
            mem_op2[wr_ptr_reg] <= bus.req_op2;
            mem_tag[wr_ptr_reg] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            wait_cnt_reg    <= '0;
            op1_reg         <= '0;
            op2_reg         <= '0;
            tag_q_reg       <= '0;
            mul_start_reg   <= 1'b0;
            mul_serv_reg    <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_result_reg  <= '0;
            rsp_tag_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !issue)
                count_reg <= count_reg + 1'b1;
            else if (!push && issue)
                count_reg <= count_reg - 1'b1;

            if (rsp_valid_reg && bus.rsp_ready) rsp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        op1_reg       <= mem_op1[rd_ptr_reg];
                        op2_reg       <= mem_op2[rd_ptr_reg];
                        tag_q_reg     <= mem_tag[rd_ptr_reg];
                        mul_start_reg <= 1'b1;
                        wait_cnt_reg  <= '0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    mul_start_reg <= 1'b0;
                    wait_cnt_reg  <= wait_cnt_reg + 1'b1;
                    if (bus.mul_done) begin
                        rsp_result_reg <= bus.mul_result;
                        rsp_tag_reg    <= tag_q_reg;
                        rsp_valid_reg  <= 1'b1;
                        mul_serv_reg   <= 1'b1;
                        state_reg      <= ACK;
                    end else if (wait_cnt_reg == 8'(TIMEOUT)) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                ACK: begin
                    mul_serv_reg <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = !full;
    assign bus.mul_start   = mul_start_reg;
    assign bus.op1         = op1_reg;
    assign bus.op2         = op2_reg;
    assign bus.mul_serv    = mul_serv_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_result  = rsp_result_reg;
    assign bus.rsp_tag     = rsp_tag_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.fifo_count  = count_reg;
endmodule
